// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// cpu_ctrl_pkg : shared types and constants for the MIPSCPU pipeline control
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // The younger (MEM) producer holds the newer value, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FWD_MEM;
    end else if (wb_hit) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// ============================================================================
// forward_unit : combinational EX-stage operand bypass selection
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module forward_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  logic mem_valid;
  logic wb_valid;
  logic mem_hit_a;
  logic mem_hit_b;
  logic wb_hit_a;
  logic wb_hit_b;

  // Register 0 is hard-wired to zero and must never be bypassed.
  assign mem_valid = mem_reg_write && (mem_rd != '0);
  assign wb_valid  = wb_reg_write  && (wb_rd  != '0);

  assign mem_hit_a = mem_valid && (mem_rd == ex_rs);
  assign mem_hit_b = mem_valid && (mem_rd == ex_rt);
  assign wb_hit_a  = wb_valid  && (wb_rd  == ex_rs);
  assign wb_hit_b  = wb_valid  && (wb_rd  == ex_rt);

  assign fwd_a = fwd_sel(mem_hit_a, wb_hit_a);
  assign fwd_b = fwd_sel(mem_hit_b, wb_hit_b);

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// hazard_controller : stall/flush/bubble sequencing and forwarding for the
//                     5-stage MIPSCPU, with memory-wait freeze and debug counters
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_stall,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic                  mem_timeout
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic       freeze;
  logic       branch_flush;
  logic       load_use;
  logic       id_dep;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  forward_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_forward_unit (
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  // A same-cycle completion in RUN never freezes; MEM_WAIT holds until ready.
  always_comb begin
    freeze = 1'b0;
    case (state)
      RUN:      freeze = mem_req && !mem_ready;
      MEM_WAIT: freeze = !mem_ready;
      default:  freeze = 1'b0;
    endcase
  end

  assign id_dep       = (ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt));
  assign branch_flush = !freeze && ex_branch_taken;
  assign load_use     = !freeze && !ex_branch_taken && ex_mem_read &&
                        (ex_rd != '0) && id_dep;

  // Controls are forced quiet while reset is held, independent of the inputs.
  assign pc_stall     = rst && (freeze || load_use);
  assign if_id_stall  = rst && (freeze || load_use);
  assign id_ex_stall  = rst && freeze;
  assign ex_mem_stall = rst && freeze;
  assign mem_wb_stall = rst && freeze;
  assign id_ex_bubble = rst && load_use;
  assign if_id_flush  = rst && branch_flush;
  assign id_ex_flush  = rst && branch_flush;
  assign fwd_a        = rst ? fwd_a_raw : FWD_RF;
  assign fwd_b        = rst ? fwd_b_raw : FWD_RF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
          // Sticky: only reset clears the timeout indication.
          if (wait_cnt == WAIT_LAST) begin
            mem_timeout <= 1'b1;
          end
          if (mem_ready) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase

      if (pc_stall && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// tb_hazard_controller : vector table plus hand sequences, scoreboard-checked
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;

  localparam int AW = 5;
  localparam int CW = 16;

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_FRZ  = 8'b1111_1000;
  localparam logic [7:0] C_LU   = 8'b1100_0100;
  localparam logic [7:0] C_BR   = 8'b0000_0011;

  typedef struct packed {
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_uses_rt;
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic [AW-1:0] ex_rd;
    logic          ex_mem_read;
    logic          ex_branch_taken;
    logic [AW-1:0] mem_rd;
    logic          mem_reg_write;
    logic [AW-1:0] wb_rd;
    logic          wb_reg_write;
    logic          mem_req;
    logic          mem_ready;
    logic [11:0]   exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rt, ex_mem_read, ex_branch_taken;
  logic          mem_reg_write, wb_reg_write, mem_req, mem_ready;
  logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic          id_ex_bubble, if_id_flush, id_ex_flush, mem_timeout;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];
  vec_t        vecs[12];

  hazard_controller #(
    .REG_ADDR_W (AW),
    .TIMEOUT    (4),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_stall     (id_ex_stall),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_stall    (mem_wb_stall),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_count     (stall_count),
    .mem_timeout     (mem_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(
    input int rs, input int rt, input logic urt,
    input int xrs, input int xrt, input int xrd, input logic mr, input logic br,
    input int mrd, input logic mw, input int wrd, input logic ww,
    input logic req, input logic rdy, input logic [11:0] e);
    vec_t v;
    v.id_rs = AW'(rs);   v.id_rt = AW'(rt);   v.id_uses_rt = urt;
    v.ex_rs = AW'(xrs);  v.ex_rt = AW'(xrt);  v.ex_rd = AW'(xrd);
    v.ex_mem_read = mr;  v.ex_branch_taken = br;
    v.mem_rd = AW'(mrd); v.mem_reg_write = mw;
    v.wb_rd = AW'(wrd);  v.wb_reg_write = ww;
    v.mem_req = req;     v.mem_ready = rdy;
    v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.id_uses_rt;
    ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rd = v.ex_rd;
    ex_mem_read = v.ex_mem_read; ex_branch_taken = v.ex_branch_taken;
    mem_rd = v.mem_rd; mem_reg_write = v.mem_reg_write;
    wb_rd = v.wb_rd; wb_reg_write = v.wb_reg_write;
    mem_req = v.mem_req; mem_ready = v.mem_ready;
  endtask

  task automatic check_out();
    logic [11:0] act;
    logic [11:0] e;
    string       nm;
    act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           id_ex_bubble, if_id_flush, id_ex_flush, fwd_a, fwd_b};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: queue empty, got %b", act);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b (stalls5,bubble,flush2,fwd_a,fwd_b)", nm, act, e);
      end
    end
  endtask

  task automatic chk_val(input string nm, input int act, input int e);
    n_checks++;
    if (act != e) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, e);
    end
  endtask

  // Drive one cycle's stimulus just after the rising edge, check mid-cycle.
  task automatic step(input vec_t v, input logic rst_val, input string nm);
    @(posedge clk);
    #1;
    rst = rst_val;
    drive(v);
    exp_q.push_back(v.exp);
    name_q.push_back(nm);
    @(negedge clk);
    check_out();
  endtask

  vec_t idle, busy, wait_br, ready_br, wait_nb, ready_nb;

  initial begin
    idle     = mkv(0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0,0, {C_NONE, 4'b0000});
    wait_br  = mkv(0,0,0, 0,0,0, 0,1, 0,0, 0,0, 1,0, {C_FRZ,  4'b0000});
    ready_br = mkv(0,0,0, 0,0,0, 0,1, 0,0, 0,0, 1,1, {C_BR,   4'b0000});
    wait_nb  = mkv(0,0,0, 0,0,0, 0,0, 0,0, 0,0, 1,0, {C_FRZ,  4'b0000});
    ready_nb = mkv(0,0,0, 0,0,0, 0,0, 0,0, 0,0, 1,1, {C_NONE, 4'b0000});
    // Everything would fire here if reset were not held.
    busy     = mkv(5,0,0, 3,3,5, 1,1, 3,1, 3,1, 1,0, {C_NONE, 4'b0000});

    vecs[0]  = mkv(0,0,0, 3,0,0, 0,0, 3,1, 3,1, 0,0, {C_NONE, 2'b10, 2'b00});
    vecs[1]  = mkv(0,0,0, 3,0,0, 0,0, 3,0, 3,1, 0,0, {C_NONE, 2'b01, 2'b00});
    vecs[2]  = mkv(0,0,0, 0,0,0, 0,0, 0,1, 0,1, 0,0, {C_NONE, 2'b00, 2'b00});
    vecs[3]  = mkv(0,0,0, 7,7,0, 0,0, 7,1, 7,1, 0,0, {C_NONE, 2'b10, 2'b10});
    vecs[4]  = mkv(0,0,0, 4,9,0, 0,0, 4,1, 9,1, 0,0, {C_NONE, 2'b10, 2'b01});
    vecs[5]  = mkv(5,0,0, 0,0,5, 1,0, 0,0, 0,0, 0,0, {C_LU,   2'b00, 2'b00});
    vecs[6]  = mkv(2,5,0, 0,0,5, 1,0, 0,0, 0,0, 0,0, {C_NONE, 2'b00, 2'b00});
    vecs[7]  = mkv(2,5,1, 0,0,5, 1,0, 0,0, 0,0, 0,0, {C_LU,   2'b00, 2'b00});
    vecs[8]  = mkv(0,0,1, 0,0,0, 1,0, 0,0, 0,0, 0,0, {C_NONE, 2'b00, 2'b00});
    vecs[9]  = mkv(5,0,0, 0,0,5, 1,1, 0,0, 0,0, 0,0, {C_BR,   2'b00, 2'b00});
    vecs[10] = mkv(5,0,0, 0,0,5, 0,0, 0,0, 0,0, 0,0, {C_NONE, 2'b00, 2'b00});
    vecs[11] = mkv(0,0,0, 0,0,0, 0,0, 0,0, 0,0, 1,1, {C_NONE, 2'b00, 2'b00});

    rst = 1'b0;
    drive(idle);
    step(busy, 1'b0, "reset_outputs");
    chk_val("reset_stall_count", int'(stall_count), 0);
    chk_val("reset_mem_timeout", int'(mem_timeout), 0);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end
    step(idle, 1'b1, "after_table");
    chk_val("table_stall_count", int'(stall_count), 2);

    // Memory wait of three frozen cycles; the taken branch must wait for release.
    step(idle, 1'b0, "rst_pulse1");
    step(wait_br, 1'b1, "wait_c1");
    step(wait_br, 1'b1, "wait_c2");
    step(wait_br, 1'b1, "wait_c3");
    step(ready_br, 1'b1, "wait_ready_flush");
    step(idle, 1'b1, "wait_back_in_run");
    chk_val("wait_stall_count", int'(stall_count), 3);
    chk_val("wait_no_timeout", int'(mem_timeout), 0);

    // Timeout with TIMEOUT=4: sets after the fourth MEM_WAIT cycle.
    step(idle, 1'b0, "rst_pulse2");
    for (int i = 1; i <= 5; i++) begin
      step(wait_nb, 1'b1, $sformatf("to_c%0d", i));
    end
    chk_val("timeout_not_yet", int'(mem_timeout), 0);
    step(wait_nb, 1'b1, "to_c6");
    chk_val("timeout_set", int'(mem_timeout), 1);
    step(wait_nb, 1'b1, "to_c7_still_frozen");
    step(ready_nb, 1'b1, "to_ready");
    chk_val("timeout_sticky", int'(mem_timeout), 1);
    chk_val("timeout_stall_count", int'(stall_count), 7);
    step(wait_nb, 1'b1, "to_rewait");
    step(busy, 1'b0, "rst_mid_wait");
    chk_val("rst_mid_timeout", int'(mem_timeout), 0);
    chk_val("rst_mid_stall_count", int'(stall_count), 0);
    step(idle, 1'b1, "after_rst_run");

    chk_val("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline sequencer for the 5-stage MIPSCPU (IF/ID/EX/MEM/WB).
- Produces per-stage stall, flush and bubble controls plus EX-stage operand forwarding selects.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug.

Parameters:
- REG_ADDR_W, 5, register-index width.
- TIMEOUT, 64, MEM_WAIT cycles before mem_timeout sets (≥2).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_rs, ex_rt  in  REG_ADDR_W  source registers in EX
- ex_rd  in  REG_ADDR_W  destination in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_rd  in  REG_ADDR_W  destination in MEM
- mem_reg_write  in  1  MEM instruction writes the register file
- wb_rd  in  REG_ADDR_W  destination in WB
- wb_reg_write  in  1  WB instruction writes the register file
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes this cycle
- pc_stall, if_id_stall  out  1  hold PC / IF-ID register
- id_ex_stall, ex_mem_stall, mem_wb_stall  out  1  hold the named register
- id_ex_bubble  out  1  load a NOP into ID/EX
- if_id_flush, id_ex_flush  out  1  clear the named register
- fwd_a, fwd_b  out  2  00 = register file, 10 = MEM result, 01 = WB result
- stall_count  out  CNT_W  cycles with pc_stall asserted, saturating
- mem_timeout  out  1  sticky error flag

Behaviour:
- Reset (rst low, async): state = RUN, stall_count = 0, mem_timeout = 0, wait counter = 0. All stall/flush/bubble outputs = 0 and fwd_a/fwd_b = 00 while rst is low.
- FSM states: RUN, MEM_WAIT.
  - RUN → MEM_WAIT when mem_req && !mem_ready.
  - MEM_WAIT → RUN when mem_ready.
  - mem_req && mem_ready in RUN: no freeze, stay in RUN.
- freeze = (RUN && mem_req && !mem_ready) || (MEM_WAIT && !mem_ready).
  - freeze asserts pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_stall.
  - During freeze, flush, bubble and load-use logic are suppressed.
- Branch: if !freeze && ex_branch_taken, assert if_id_flush and id_ex_flush in the same cycle. No stall, 2-cycle penalty.
- Load-use:
  - Condition: !freeze && !ex_branch_taken && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt)).
  - Action: assert pc_stall, if_id_stall and id_ex_bubble for exactly that cycle.
- Priority: freeze > branch flush > load-use.
- Forwarding (combinational, independent of FSM):
  - fwd_a = 10 if mem_reg_write && mem_rd != 0 && mem_rd == ex_rs.
  - Otherwise fwd_a = 01 if wb_reg_write && wb_rd != 0 && wb_rd == ex_rs.
  - Otherwise fwd_a = 00.
  - fwd_b: same rule using ex_rt. MEM match beats WB match.
- Wait counter:
  - Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
  - When it reaches TIMEOUT, mem_timeout sets and stays set until reset. The FSM stays in MEM_WAIT and freeze continues.
  - The counter saturates at TIMEOUT.
- stall_count: +1 on each clock edge where pc_stall was 1; holds at 2^CNT_W−1.
- Reset mid-MEM_WAIT returns to RUN and clears all state immediately.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - FSM state enum {RUN, MEM_WAIT}.
  - Forward-select constants FWD_RF = 00, FWD_MEM = 10, FWD_WB = 01.
  - REG_ADDR_W default.
- One natural sub-module: forward_unit (purely combinational fwd_a/fwd_b).
- FSM, hazard detection and counters stay in the top module.

Test Plan:
- Forwarding priority: ex_rs = 3, mem_rd = 3, mem_reg_write = 1, wb_rd = 3, wb_reg_write = 1 → fwd_a = 10. Then mem_reg_write = 0 → fwd_a = 01. Then ex_rs = 0 with matching rd = 0 → fwd_a = 00.
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs = 5 → pc_stall = if_id_stall = id_ex_bubble = 1 for one cycle and stall_count = 1. With id_rt = 5, id_uses_rt = 0 and id_rs ≠ 5 → no stall.
- Branch vs load-use: ex_branch_taken = 1 with the load-use condition true → if_id_flush = id_ex_flush = 1 and id_ex_bubble = 0.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, then mem_ready = 1:
  - All five stall outputs are 1 for 3 cycles and 0 on the ready cycle.
  - State is back in RUN; stall_count = 3.
  - A branch asserted during the wait produces flush only after release.
- Timeout with TIMEOUT = 4: mem_ready is held 0 → mem_timeout rises after 4 MEM_WAIT cycles and remains 1 after mem_ready. Drive rst low mid-wait → all outputs 0 and mem_timeout = 0.
